int_mul_ctrl: RTL

//  Front/back end for int_mul in the execute stage. Accepts two's-complement operands over valid/ready.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/sm_conv.sv | 13 +
 rtl/int_mul_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the integer multiply front end: FSM encodings, the INT_MIN operand
// and the two's-complement <-> sign-magnitude helpers.
package alu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_ISSUE     = 3'd1;
    localparam state_t ST_WAIT_LOW  = 3'd2;
    localparam state_t ST_WAIT_HIGH = 3'd3;
    localparam state_t ST_HOLD      = 3'd4;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Low 31 bits of |x|; INT_MIN wraps to 0 here and must be filtered by the caller.
    function automatic logic [31:0] tc_to_sm(input logic [31:0] x);
        logic [30:0] mag;
        mag = x[31] ? (~x[30:0] + 31'd1) : x[30:0];
        return {x[31], mag};
    endfunction

    // A negative zero (s=1, m=0) comes out as plain 0.
    function automatic logic [31:0] sm_to_tc(input logic [31:0] x);
        logic [31:0] ext;
        ext = {1'b0, x[30:0]};
        return x[31] ? (~ext + 32'd1) : ext;
    endfunction

endpackage

// File: rtl/sm_conv.sv
// Combinational 32-bit converter: i_to_sm=1 gives sign-magnitude from two's complement,
// i_to_sm=0 gives two's complement from sign-magnitude.
module sm_conv
    import alu_pkg::*;
(
    input  logic        i_to_sm,
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);

    assign o_y = i_to_sm ? tc_to_sm(i_x) : sm_to_tc(i_x);

endmodule

// File: rtl/int_mul_ctrl.sv
// Execute-stage wrapper around int_mul: converts operands to sign-magnitude, issues one op,
// waits for a fresh result, converts it back and holds it for writeback.
module int_mul_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 63
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_mul_valid,
    output logic [31:0]      o_mul_a,
    output logic [31:0]      o_mul_b,
    input  logic             i_mul_valid,
    input  logic [31:0]      i_mul_result,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_ovf,
    output logic             o_err,
    output logic [2:0]       o_dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [31:0]      mul_a_q, mul_a_d;
    logic [31:0]      mul_b_q, mul_b_d;
    logic [31:0]      res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [31:0]      a_sm, b_sm, res_tc;
    logic [TMR_W-1:0] timer_inc;
    logic             timer_hit;
    logic             zero_op, min_op;

    sm_conv u_conv_a (
        .i_to_sm (1'b1),
        .i_x     (i_a),
        .o_y     (a_sm)
    );

    sm_conv u_conv_b (
        .i_to_sm (1'b1),
        .i_x     (i_b),
        .o_y     (b_sm)
    );

    sm_conv u_conv_res (
        .i_to_sm (1'b0),
        .i_x     (i_mul_result),
        .o_y     (res_tc)
    );

    assign zero_op   = (i_a == 32'd0) || (i_b == 32'd0);
    assign min_op    = (i_a == INT_MIN) || (i_b == INT_MIN);
    assign timer_inc = timer_q + TMR_W'(1);
    assign timer_hit = (timer_inc == TMR_MAX);

    // Both sides use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid and its payload stay put until that edge.
    always_comb begin
        state_d = state_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        res_d   = res_q;
        tag_d   = tag_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    mul_a_d = a_sm;
                    mul_b_d = b_sm;
                    tag_d   = i_tag;
                    if (zero_op) begin
                        state_d = ST_HOLD;
                        res_d   = 32'd0;
                    end else if (min_op) begin
                        state_d = ST_HOLD;
                        res_d   = 32'd0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT_LOW;
            end
            // A high valid here is the previous op's DONE level or its delayed copy.
            ST_WAIT_LOW: begin
                timer_d = timer_inc;
                if (timer_hit) begin
                    state_d = ST_HOLD;
                    res_d   = 32'd0;
                    err_d   = 1'b1;
                end else if (!i_mul_valid) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                timer_d = timer_inc;
                if (i_mul_valid) begin
                    state_d = ST_HOLD;
                    res_d   = res_tc;
                end else if (timer_hit) begin
                    state_d = ST_HOLD;
                    res_d   = 32'd0;
                    err_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            res_q   <= 32'd0;
            tag_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_mul_valid = (state_q == ST_ISSUE);
    assign o_valid     = (state_q == ST_HOLD);
    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;
    assign o_result    = res_q;
    assign o_tag       = tag_q;
    assign o_ovf       = ovf_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule
